// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: one single-port RAM is shared between display prefetch
// (which has priority) and a pixel writer whose starvation is bounded.
module vga_fb_arbiter #(
    parameter int H_PIXELS    = 640,
    parameter int V_PIXELS    = 480,
    parameter int ADDR_W      = 19,
    parameter int FIFO_DEPTH  = 8,
    parameter int WR_MAX_WAIT = 16
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [2:0]        pix_data,
    output logic              pix_valid,
    output logic              underrun,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata
);

    localparam int TOTAL  = H_PIXELS * V_PIXELS;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(WR_MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_WAIT_FRAME,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] eff_addr;
    logic [2:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              rdata_valid;
    logic [WAIT_W-1:0] wait_cnt;
    logic              disp_ok, wr_ok, grant_wr, issue_rd;
    logic              push, pop;

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) state <= S_WAIT_FRAME;
        else          state <= state_next;
    end

    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    always_comb begin
        state_next = state;
        eff_addr   = rd_addr;
        occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(mem_re) + (CNT_W+1)'(rdata_valid);
        disp_ok    = 1'b0;
        wr_ok      = 1'b0;
        grant_wr   = 1'b0;
        issue_rd   = 1'b0;
        // A restart flushes the FIFO and drops in-flight data, so the fetch sees an empty pipe.
        if (frame_start) begin
            eff_addr   = '0;
            occupancy  = '0;
            state_next = S_ACTIVE;
        end
        disp_ok  = (frame_start || state == S_ACTIVE) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        wr_ok    = wr_req && !wr_ack;
        grant_wr = wr_ok && ((wait_cnt >= WAIT_W'(WR_MAX_WAIT)) || !disp_ok);
        issue_rd = disp_ok && !grant_wr;
        if (issue_rd && eff_addr == LAST_ADDR) state_next = S_DONE;
    end

    assign push = rdata_valid && !frame_start;
    assign pop  = pix_pop && (fifo_count != '0);

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            rd_addr     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rdata_valid <= 1'b0;
            wait_cnt    <= '0;
            underrun    <= 1'b0;
            wr_ack      <= 1'b0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            // Data returning the cycle after a restart belongs to the old frame.
            rdata_valid <= mem_re && !frame_start;
            underrun    <= underrun | (pix_pop && fifo_count == '0);

            if (frame_start) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                unique case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end

            if (!wr_req || grant_wr)
                wait_cnt <= '0;
            else if (wr_ok && wait_cnt < WAIT_W'(WR_MAX_WAIT))
                wait_cnt <= wait_cnt + WAIT_W'(1);

            wr_ack <= grant_wr;
            mem_we <= grant_wr;
            mem_re <= issue_rd;
            if (grant_wr) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (issue_rd) begin
                mem_addr <= eff_addr;
            end

            // The address parks on the last pixel so it never runs past the frame.
            if (issue_rd)
                rd_addr <= (eff_addr == LAST_ADDR) ? eff_addr : eff_addr + ADDR_W'(1);
            else if (frame_start)
                rd_addr <= '0;
        end
    end

    // NOTE: FIFO storage is left unreset; pix_valid and pix_data gating hide stale entries.
    always_ff @(posedge pixel_clock) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end

    assign pix_valid = (fifo_count != '0);
    assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : 3'b000;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter on a reduced 40x30 frame with a behavioural RAM.
module tb_vga_fb_arbiter;

    localparam int H      = 40;
    localparam int V      = 30;
    localparam int TOTAL  = H * V;
    localparam int AW     = 12;

    logic          pixel_clock;
    logic          reset_n;
    logic          frame_start;
    logic          pix_pop;
    logic [2:0]    pix_data;
    logic          pix_valid;
    logic          underrun;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [2:0]    mem_wdata;
    logic [2:0]    mem_rdata = 3'b000;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] wmem [int];
    logic [2:0] exp_q [$];

    typedef struct {
        logic          re;
        logic [AW-1:0] addr;
        logic          valid;
    } fetch_vec_t;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic [2:0]    data;
        logic          ack;
        logic [AW-1:0] maddr;
        logic [2:0]    wdata;
    } wr_vec_t;

    fetch_vec_t fv [11];
    wr_vec_t    wv [5];

    vga_fb_arbiter #(
        .H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW), .FIFO_DEPTH(8), .WR_MAX_WAIT(16)
    ) dut (
        .pixel_clock(pixel_clock),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .pix_pop    (pix_pop),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .underrun   (underrun),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    // Unwritten locations hold addr[2:0].
    function automatic logic [2:0] ram_val(input logic [AW-1:0] a);
        if (wmem.exists(int'(a))) return wmem[int'(a)];
        return a[2:0];
    endfunction

    always @(posedge pixel_clock) begin
        if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
        if (mem_re) mem_rdata <= ram_val(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        pix_pop     = 1'b0;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, popped, nreads, order_err, extra, n;
        logic [AW-1:0] last_rd;

        for (int i = 0; i < 11; i++) begin
            fv[i].re    = (i + 1 <= 8);
            fv[i].addr  = AW'(i);
            fv[i].valid = (i + 1 >= 3);
        end
        wv[0] = '{req: 1'b1, addr: 12'h100, data: 3'd5, ack: 1'b0, maddr: 12'h000, wdata: 3'd0};
        wv[1] = '{req: 1'b1, addr: 12'h101, data: 3'd3, ack: 1'b1, maddr: 12'h100, wdata: 3'd5};
        wv[2] = '{req: 1'b1, addr: 12'h101, data: 3'd3, ack: 1'b0, maddr: 12'h000, wdata: 3'd0};
        wv[3] = '{req: 1'b0, addr: 12'h000, data: 3'd0, ack: 1'b1, maddr: 12'h101, wdata: 3'd3};
        wv[4] = '{req: 1'b0, addr: 12'h000, data: 3'd0, ack: 1'b0, maddr: 12'h000, wdata: 3'd0};

        // Reset dominates active inputs.
        reset_n = 1'b0; frame_start = 1'b1; pix_pop = 1'b1; wr_req = 1'b1;
        wr_addr = 12'hABC; wr_data = 3'd7;
        tick(); tick();
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data",  pix_data, 0);
        check("rst_underrun",  underrun, 0);
        check("rst_wr_ack",    wr_ack, 0);
        check("rst_mem_we",    mem_we, 0);
        check("rst_mem_re",    mem_re, 0);
        check("rst_mem_addr",  mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);

        // Initial prefetch with no pops: exactly FIFO_DEPTH reads.
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("fetch_c%0d_re", i + 1), mem_re, fv[i].re);
            if (fv[i].re) check($sformatf("fetch_c%0d_addr", i + 1), mem_addr, fv[i].addr);
            check($sformatf("fetch_c%0d_valid", i + 1), pix_valid, fv[i].valid);
            tick();
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_re) extra++;
            tick();
        end
        check("fetch_no_more_reads", extra, 0);
        check("fetch_underrun", underrun, 0);

        // Full frame drained one pixel per cycle from cycle 4.
        do_reset();
        frame_start = 1'b1;
        for (int a = 0; a < TOTAL; a++) exp_q.push_back(a[2:0]);
        tick();
        frame_start = 1'b0;
        cyc = 1; popped = 0; nreads = 0; order_err = 0; last_rd = '0;
        while (popped < TOTAL && cyc < TOTAL + 100) begin
            pix_pop = (cyc >= 4);
            if (mem_re) begin
                if (mem_addr != AW'(nreads)) order_err++;
                last_rd = mem_addr;
                nreads++;
            end
            if (pix_pop && pix_valid) begin
                check("frame_pixel", pix_data, exp_q.pop_front());
                popped++;
            end
            tick();
            cyc++;
        end
        pix_pop = 1'b0;
        check("frame_popped", popped, TOTAL);
        check("frame_reads", nreads, TOTAL);
        check("frame_last_addr", last_rd, TOTAL - 1);
        check("frame_read_order", order_err, 0);
        check("frame_underrun", underrun, 0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_re) extra++;
            tick();
        end
        check("frame_done_idle", extra, 0);

        // Restart mid-frame while reads of 998/999 are still in flight.
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cyc = 1;
        while (!(mem_re && mem_addr == AW'(999)) && cyc < 1100) begin
            pix_pop = (cyc >= 4);
            tick();
            cyc++;
        end
        check("restart_reached_999", mem_addr, 999);
        pix_pop = 1'b0;
        frame_start = 1'b1;
        exp_q.delete();
        for (int a = 0; a < 8; a++) exp_q.push_back(a[2:0]);
        tick();
        frame_start = 1'b0;
        check("restart_fifo_empty", pix_valid, 0);
        check("restart_mem_re", mem_re, 1);
        check("restart_mem_addr", mem_addr, 0);
        repeat (12) tick();
        for (int i = 0; i < 8; i++) begin
            pix_pop = 1'b1;
            check($sformatf("restart_pix%0d_valid", i), pix_valid, 1);
            check($sformatf("restart_pix%0d", i), pix_data, exp_q.pop_front());
            tick();
        end
        pix_pop = 1'b0;
        check("restart_underrun", underrun, 0);

        // Underrun is sticky across frame_start and cleared only by reset.
        do_reset();
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        check("urun_set", underrun, 1);
        check("urun_pix_data", pix_data, 0);
        check("urun_pix_valid", pix_valid, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
        check("urun_frame_running", pix_valid, 1);
        check("urun_sticky", underrun, 1);
        reset_n = 1'b0;
        tick();
        check("urun_cleared", underrun, 0);
        reset_n = 1'b1;

        // Writes while waiting for a frame: held request, then 1 write per 2 cycles.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_req  = wv[i].req;
            wr_addr = wv[i].addr;
            wr_data = wv[i].data;
            check($sformatf("wr_c%0d_ack", i), wr_ack, wv[i].ack);
            check($sformatf("wr_c%0d_we", i), mem_we, wv[i].ack);
            if (wv[i].ack) begin
                check($sformatf("wr_c%0d_addr", i), mem_addr, wv[i].maddr);
                check($sformatf("wr_c%0d_wdata", i), mem_wdata, wv[i].wdata);
            end
            tick();
        end
        wr_req = 1'b0;
        check("wr_ram_100", ram_val(12'h100), 5);
        check("wr_ram_101", ram_val(12'h101), 3);

        // Saturated FIFO, no pops: writer granted on the next cycle.
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (20) tick();
        wr_req = 1'b1; wr_addr = 12'h200; wr_data = 3'd6;
        tick();
        check("sat_wr_ack", wr_ack, 1);
        check("sat_mem_addr", mem_addr, 12'h200);
        wr_req = 1'b0;
        tick();
        check("sat_ram_200", ram_val(12'h200), 6);

        // Reads always eligible: forced grant after 16 denied cycles.
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            pix_pop = (c >= 4);
            tick();
        end
        wr_req = 1'b1; wr_addr = 12'h300; wr_data = 3'd2;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wr_ack && n < 40);
        check("force_ack_latency", n, 17);
        check("force_mem_we", mem_we, 1);
        check("force_mem_addr", mem_addr, 12'h300);
        check("force_mem_wdata", mem_wdata, 2);
        wr_req = 1'b0;
        repeat (4) tick();
        pix_pop = 1'b0;
        check("force_underrun", underrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (1 access/cycle, 3-bit RGB words, 1-cycle read latency) between two requesters: display pixel fetch and a pixel writer (drawing engine/CPU).
- Prefetches display pixels into a small FIFO drained by the VGA sync block's video_on, at one pixel per pixel_clock.
- Display reads have priority; a wait counter bounds writer starvation.

Parameters:
- H_PIXELS, 640, visible pixels per line
- V_PIXELS, 480, visible lines per frame
- ADDR_W, 19, framebuffer address width (must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS)
- FIFO_DEPTH, 8, display prefetch FIFO entries (power of 2, >= 4)
- WR_MAX_WAIT, 16, cycles a pending write may be denied before forced grant

Ports:
- pixel_clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous active-low reset
- frame_start  in  1  1-cycle pulse; restarts display fetch at address 0
- pix_pop  in  1  consume FIFO head (driven by video_on)
- pix_data  out  3  RGB at FIFO head; valid when pix_valid=1
- pix_valid  out  1  FIFO non-empty
- underrun  out  1  sticky: pop seen while FIFO empty
- wr_req  in  1  writer request; hold with addr/data until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  3  write RGB
- wr_ack  out  1  1-cycle pulse; the write is being performed this cycle
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_re  out  1  RAM read enable (registered)
- mem_wdata  out  3  RAM write data (registered)
- mem_rdata  in  3  RAM read data, valid the cycle after mem_re=1

Behaviour:
Reset (reset_n=0 at a clock edge):
- state=S_WAIT_FRAME; FIFO empty; rd_addr=0; wait counter=0.
- Outputs: pix_valid=0, pix_data=0, underrun=0, wr_ack=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.

States:
- S_WAIT_FRAME: no display reads; writer granted every eligible cycle. frame_start -> S_ACTIVE.
- S_ACTIVE: display reads issued per the arbitration rules. Last read issued at rd_addr=H_PIXELS*V_PIXELS-1 -> S_DONE.
- S_DONE: writer only; FIFO keeps draining. frame_start -> S_ACTIVE.
- frame_start in any state, including mid-frame:
  - flush FIFO; rd_addr=0; enter S_ACTIVE;
  - discard any read data returning the following cycle;
  - underrun is not cleared.

Arbitration (decided in cycle N from current inputs/state; mem_* registered and valid in cycle N+1):
- disp_ok = S_ACTIVE and (fifo_count + reads_in_flight) < FIFO_DEPTH. reads_in_flight counts reads issued but not yet pushed (0..2).
- wr_ok = wr_req and wr_ack not asserted in cycle N. This prevents a duplicate grant of a held request; back-to-back writes therefore run at 1 per 2 cycles.
- Priority:
  1. wr_ok and wait >= WR_MAX_WAIT -> grant writer.
  2. else disp_ok -> issue read, rd_addr++.
  3. else wr_ok -> grant writer.
  4. else idle (mem_we=mem_re=0; mem_addr holds).
- Writer grant in N: cycle N+1 has mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
- Read issued in N: cycle N+1 has mem_re=1, mem_addr=rd_addr. mem_rdata is pushed at the end of N+2; it is at the head by N+3 if the FIFO was empty.
- wait counter: +1 per cycle with wr_ok=1 not granted, saturating at WR_MAX_WAIT; cleared on writer grant or when wr_req=0.

FIFO:
- Show-ahead: pix_data = head entry; pix_valid = count>0.
- Push and pop in the same cycle are allowed; count is unchanged.
- Overflow cannot occur (reservation rule above).
- pix_pop with count=0: no state change, pix_data=0, underrun<=1. Stays 1 until reset.
- Pop while pix_valid=1 advances the head next cycle.

Width/wrap rules:
- rd_addr never exceeds H_PIXELS*V_PIXELS-1. No reads are issued past the end of frame.
- wr_addr is not range-checked; it is passed through to the RAM.

Test Plan:
- Reset, frame_start at cycle 0, no pops -> mem_re=1 on cycles 1..8 with addresses 0..7, then none; pix_valid=1 by cycle 3; FIFO count=8; underrun=0.
- Full frame with pix_pop=1 every cycle starting 4 cycles after frame_start -> 307200 pixels popped in address order (check RAM pattern data=addr[2:0]); last read at address 307199; state S_DONE; underrun=0.
- wr_req held in S_WAIT_FRAME with addr 0x100, data 3'b101 -> wr_ack=1 and mem_we=1 one cycle later; RAM[0x100]=5. Keep wr_req high with new addr after ack -> next ack 2 cycles later, no duplicate write.
- Continuous pops in S_ACTIVE plus a write request -> writer gets a slot. Force a saturated FIFO with no pops and check the writer is granted within 1 cycle; then, with pops and reads always eligible, check forced grant after exactly 16 denied cycles.
- pix_pop=1 right after reset (FIFO empty) -> underrun=1, pix_data=0; underrun stays 1 across a later frame_start; cleared only by reset_n=0.
- frame_start mid-frame at rd_addr=1000 with a read in flight -> FIFO empty next cycle; stale data dropped; next reads start at address 0; first popped pixel = RAM[0].
